// File: rtl/timing_control_unit.sv
// Sequence counter and instruction-cycle controller.
// Turns the decoded opcode into one-hot T states and fetch/decode/execute strobes.
module timing_control_unit #(
   parameter int SC_WIDTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     halt,
   input  logic [7:0]               instruction,
   input  logic                     ir_i,
   output logic [2**SC_WIDTH-1:0]   timing,
   output logic                     fetch_ar_pc,
   output logic                     fetch_ir_mem,
   output logic                     pc_inc,
   output logic                     decode_ld,
   output logic                     indirect_rd,
   output logic                     exec_en,
   output logic                     instr_done,
   output logic [7:0]               d_latched,
   output logic                     running,
   output logic                     illegal
);

   localparam int TW = 2**SC_WIDTH;
   localparam logic [SC_WIDTH-1:0] SC_T0 = SC_WIDTH'(0);
   localparam logic [SC_WIDTH-1:0] SC_T1 = SC_WIDTH'(1);
   localparam logic [SC_WIDTH-1:0] SC_T2 = SC_WIDTH'(2);
   localparam logic [SC_WIDTH-1:0] SC_T3 = SC_WIDTH'(3);
   localparam logic [SC_WIDTH-1:0] SC_T4 = SC_WIDTH'(4);
   localparam logic [SC_WIDTH-1:0] SC_T5 = SC_WIDTH'(5);
   localparam logic [SC_WIDTH-1:0] SC_T6 = SC_WIDTH'(6);
   localparam logic [SC_WIDTH-1:0] SC_T7 = SC_WIDTH'(7);

   logic [SC_WIDTH-1:0] r_sc;
   logic                r_run;
   logic [7:0]          r_d;
   logic                r_i;
   logic                r_illegal;

   logic [SC_WIDTH-1:0] w_last;
   logic                w_onehot;
   logic                w_bad_sc;
   logic                w_t2;
   logic                w_done;
   logic                w_exec;

   assign w_onehot = (instruction != 8'h00) &&
                     ((instruction & (instruction - 8'd1)) == 8'h00);
   assign w_bad_sc = r_run && (r_sc >= SC_T7);
   assign w_t2     = r_run && (r_sc == SC_T2);

   // Final T state per opcode; zero means no legal opcode is latched
   always_comb begin
      w_last = SC_T0;
      if (r_d[7])
         w_last = SC_T3;
      else if (r_d[3] || r_d[4])
         w_last = SC_T4;
      else if (r_d[0] || r_d[1] || r_d[2] || r_d[5])
         w_last = SC_T5;
      else if (r_d[6])
         w_last = SC_T6;
   end

   assign w_done = r_run && !w_bad_sc && (r_sc >= SC_T3) &&
                   (r_sc == w_last);

   assign w_exec = r_run && !w_bad_sc &&
                   ((r_d[7] && (r_sc == SC_T3)) ||
                    (!r_d[7] && (r_d[6:0] != 7'h00) &&
                     (r_sc >= SC_T4) && (r_sc <= w_last)));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sc      <= SC_T0;
         r_run     <= 1'b0;
         r_d       <= 8'h00;
         r_i       <= 1'b0;
         r_illegal <= 1'b0;
      end else if (!r_run) begin
         r_sc <= SC_T0;
         if (start && !r_illegal)
            r_run <= 1'b1;
      end else if (w_bad_sc) begin
         r_sc      <= SC_T0;
         r_run     <= 1'b0;
         r_illegal <= 1'b1;
      end else if (w_t2) begin
         r_d <= instruction;
         r_i <= ir_i;
         if (w_onehot) begin
            r_sc <= SC_T3;
         end else begin
            r_sc      <= SC_T0;
            r_run     <= 1'b0;
            r_illegal <= 1'b1;
         end
      end else if (w_done) begin
         r_sc <= SC_T0;
         if (halt)
            r_run <= 1'b0;
      end else begin
         r_sc <= r_sc + SC_WIDTH'(1);
      end
   end

   assign timing       = r_run ? (TW'(1) << r_sc) : '0;
   assign fetch_ar_pc  = r_run && (r_sc == SC_T0);
   assign fetch_ir_mem = r_run && (r_sc == SC_T1);
   assign pc_inc       = r_run && (r_sc == SC_T1);
   assign decode_ld    = w_t2;
   assign indirect_rd  = r_run && (r_sc == SC_T3) && !r_d[7] &&
                         (r_d[6:0] != 7'h00) && r_i;
   assign exec_en      = w_exec;
   assign instr_done   = w_done;
   assign d_latched    = r_d;
   assign running      = r_run;
   assign illegal      = r_illegal;

   logic w_unused;
   assign w_unused = (SC_T5 == SC_T6) | (SC_T4 == SC_T1);

endmodule

// File: tb/tb_timing_control_unit.sv
// Directed bench for timing_control_unit: per-opcode table plus
// back-to-back, halt/resume, illegal-opcode and async-reset sequences.
module tb_timing_control_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic        halt;
   logic [7:0]  instruction;
   logic        ir_i;
   logic [15:0] timing;
   logic        fetch_ar_pc;
   logic        fetch_ir_mem;
   logic        pc_inc;
   logic        decode_ld;
   logic        indirect_rd;
   logic        exec_en;
   logic        instr_done;
   logic [7:0]  d_latched;
   logic        running;
   logic        illegal;

   int total = 0;
   int bad   = 0;

   timing_control_unit #(.SC_WIDTH(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .halt         (halt),
      .instruction  (instruction),
      .ir_i         (ir_i),
      .timing       (timing),
      .fetch_ar_pc  (fetch_ar_pc),
      .fetch_ir_mem (fetch_ir_mem),
      .pc_inc       (pc_inc),
      .decode_ld    (decode_ld),
      .indirect_rd  (indirect_rd),
      .exec_en      (exec_en),
      .instr_done   (instr_done),
      .d_latched    (d_latched),
      .running      (running),
      .illegal      (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] instr;
      logic       ir;
      logic [3:0] last;
      logic       ind;
      logic [3:0] exf;
   } vec_t;

   vec_t vecs [9];

   function automatic logic [23:0] outs();
      return {timing, fetch_ar_pc, fetch_ir_mem, pc_inc, decode_ld,
              indirect_rd, exec_en, instr_done, running};
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [23:0] e;
      logic [15:0] one;

      vecs[0] = '{instr: 8'h80, ir: 1'b0, last: 4'd3, ind: 1'b0, exf: 4'd3};
      vecs[1] = '{instr: 8'h80, ir: 1'b1, last: 4'd3, ind: 1'b0, exf: 4'd3};
      vecs[2] = '{instr: 8'h01, ir: 1'b1, last: 4'd5, ind: 1'b1, exf: 4'd4};
      vecs[3] = '{instr: 8'h02, ir: 1'b0, last: 4'd5, ind: 1'b0, exf: 4'd4};
      vecs[4] = '{instr: 8'h04, ir: 1'b1, last: 4'd5, ind: 1'b1, exf: 4'd4};
      vecs[5] = '{instr: 8'h08, ir: 1'b0, last: 4'd4, ind: 1'b0, exf: 4'd4};
      vecs[6] = '{instr: 8'h10, ir: 1'b0, last: 4'd4, ind: 1'b0, exf: 4'd4};
      vecs[7] = '{instr: 8'h20, ir: 1'b1, last: 4'd5, ind: 1'b1, exf: 4'd4};
      vecs[8] = '{instr: 8'h40, ir: 1'b0, last: 4'd6, ind: 1'b0, exf: 4'd4};

      reset = 1'b1;
      start = 1'b0;
      halt = 1'b0;
      instruction = 8'h00;
      ir_i = 1'b0;
      #1;
      chk("reset_outs", 32'(outs()), 32'h0);
      chk("reset_flags", {22'h0, illegal, 1'b0, d_latched}, 32'h0);
      tick();
      tick();
      reset = 1'b0;
      tick();
      chk("idle_outs", 32'(outs()), 32'h0);

      // one instruction per record, start+halt together while stopped
      foreach (vecs[n]) begin
         instruction = vecs[n].instr;
         ir_i = vecs[n].ir;
         halt = 1'b1;
         start = 1'b1;
         tick();
         start = 1'b0;
         for (int c = 0; c <= int'(vecs[n].last); c++) begin
            one = 16'h1 << c;
            e = {one, c == 0, c == 1, c == 1, c == 2,
                 (c == 3) && vecs[n].ind,
                 (c >= int'(vecs[n].exf)) && (c <= int'(vecs[n].last)),
                 c == int'(vecs[n].last), 1'b1};
            chk($sformatf("vec%0d_T%0d", n, c), 32'(outs()), 32'(e));
            tick();
         end
         chk($sformatf("vec%0d_stop", n), 32'(outs()), 32'h0);
         chk($sformatf("vec%0d_d", n), 32'(d_latched), 32'(vecs[n].instr));
      end

      // back-to-back D7 without halt, start held one cycle
      instruction = 8'h80;
      ir_i = 1'b0;
      halt = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         one = 16'h1 << (k % 4);
         chk($sformatf("b2b_t%0d", k), 32'(timing), 32'(one));
         chk($sformatf("b2b_done%0d", k), 32'(instr_done), 32'((k % 4) == 3));
         tick();
      end
      halt = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("held%0d", k), {15'h0, running, timing}, 32'h0);
         tick();
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("resume_t0", {15'h0, running, timing}, 32'h10001);
      for (int k = 0; k < 4; k++) tick();
      chk("resume_stop", 32'(running), 32'h0);

      // non-one-hot opcode at T2
      instruction = 8'h03;
      halt = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("ill_t2", 32'(decode_ld), 32'h1);
      tick();
      chk("ill_flag", {14'h0, illegal, running, timing}, 32'h20000);
      start = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("ill_ignore%0d", k), {15'h0, running, timing}, 32'h0);
      end
      start = 1'b0;
      reset = 1'b1;
      #1;
      chk("ill_clr", 32'(illegal), 32'h0);
      tick();
      reset = 1'b0;
      tick();

      // zero opcode is also illegal
      instruction = 8'h00;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      chk("ill_zero", {14'h0, illegal, running, 16'h0}, 32'h20000);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();

      // async reset at T4 of D5
      instruction = 8'h20;
      ir_i = 1'b0;
      halt = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      chk("d5_t4", {15'h0, exec_en, timing}, 32'h10010);
      #2;
      reset = 1'b1;
      #1;
      chk("async_outs", 32'(outs()), 32'h0);
      chk("async_d", 32'(d_latched), 32'h0);
      tick();
      reset = 1'b0;
      for (int k = 0; k < 2; k++) begin
         tick();
         chk($sformatf("post_rst%0d", k), 32'(outs()), 32'h0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule
